// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: parametrised carry-select adder, one pipeline
// stage per BLOCK-bit slice, with a valid/ready handshake on both sides.
//
// Parameters:
//   WIDTH  operand/sum width (must be a multiple of BLOCK)
//   BLOCK  bits per carry-select block; NUM_STAGES = WIDTH / BLOCK
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set A/B/cin presented
//   in_ready   adder can take an operand set (combinational from out_valid/out_ready)
//   A, B, cin  operands and carry-in
//   out_valid  S/cout hold a result
//   out_ready  consumer takes the result
//   S, cout    (A + B + cin) mod 2^WIDTH and carry out of bit WIDTH-1
//   ovf        signed overflow flag (only when CSA_OVERFLOW_FLAG_EN is defined)
//
// Optional feature macro: CSA_OVERFLOW_FLAG_EN adds the registered ovf output.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout
`ifdef CSA_OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NUM_STAGES = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_carry_select_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Per-stage registers. Operands are kept shifted so each stage always
    // consumes the low block; the sum is shifted in from the top so that after
    // the last stage it sits in its final position.
    logic             vld_q   [NUM_STAGES];
    logic             carry_q [NUM_STAGES];
    logic [WIDTH-1:0] a_q     [NUM_STAGES];
    logic [WIDTH-1:0] b_q     [NUM_STAGES];
    logic [WIDTH-1:0] s_q     [NUM_STAGES];

    // Whole pipeline moves unless the output holds a result nobody takes.
    logic advance;
    assign advance  = !(vld_q[NUM_STAGES-1] && !out_ready);
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic [BLOCK:0]   sum0;
        logic [BLOCK:0]   sum1;
        logic [BLOCK:0]   sel;

        if (k == 0) begin : g_first
            // Bubbles enter as all zeros, so their sum and carry stay zero downstream.
            assign v_in = in_valid;
            assign c_in = in_valid & cin;
            assign a_in = in_valid ? A : '0;
            assign b_in = in_valid ? B : '0;
            assign s_in = '0;
        end else begin : g_next
            assign v_in = vld_q[k-1];
            assign c_in = carry_q[k-1];
            assign a_in = a_q[k-1];
            assign b_in = b_q[k-1];
            assign s_in = s_q[k-1];
        end

        // Both candidate sums are formed before the carry is known.
        assign sum0 = {1'b0, a_in[BLOCK-1:0]} + {1'b0, b_in[BLOCK-1:0]};
        assign sum1 = sum0 + (BLOCK+1)'(1);
        assign sel  = c_in ? sum1 : sum0;

        // Stage register: holds on stall, otherwise shifts including bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[k]   <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
            end else if (advance) begin
                vld_q[k]   <= v_in;
                carry_q[k] <= sel[BLOCK];
                a_q[k]     <= a_in >> BLOCK;
                b_q[k]     <= b_in >> BLOCK;
                s_q[k]     <= (s_in >> BLOCK) | (WIDTH'(sel[BLOCK-1:0]) << (WIDTH - BLOCK));
            end
        end

`ifdef CSA_OVERFLOW_FLAG_EN
        if (k == NUM_STAGES - 1) begin : g_ovf
            logic ovf_q;
            // Carry into the MSB equals a ^ b ^ sum at that bit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= a_in[BLOCK-1] ^ b_in[BLOCK-1] ^ sel[BLOCK-1] ^ sel[BLOCK];
                end
            end
            assign ovf = ovf_q;
        end
`endif
    end

    assign out_valid = vld_q[NUM_STAGES-1];
    assign S         = s_q[NUM_STAGES-1];
    assign cout      = carry_q[NUM_STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder: directed vectors on a
// 16/4 instance plus random traffic on 8/8 and 32/8 instances, all checked
// against an arithmetic reference model held in queues.
module tb_pipelined_carry_select_adder;

    localparam int unsigned N = 4;

    logic clk, rst;

    // Default instance 16/4
    logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] A, B, S;
    logic        ovf0, ovf8, ovf32;
    // Sweep instances
    logic        iv8, ir8, c8, ov8, or8, co8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, c32, ov32, or32, co32;
    logic [31:0] a32, b32, s32;

    pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .cout(cout)
`ifdef CSA_OVERFLOW_FLAG_EN
        , .ovf(ovf0)
`endif
    );

    pipelined_carry_select_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cin(c8), .out_valid(ov8), .out_ready(or8),
        .S(s8), .cout(co8)
`ifdef CSA_OVERFLOW_FLAG_EN
        , .ovf(ovf8)
`endif
    );

    pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .cin(c32), .out_valid(ov32), .out_ready(or32),
        .S(s32), .cout(co32)
`ifdef CSA_OVERFLOW_FLAG_EN
        , .ovf(ovf32)
`endif
    );

`ifndef CSA_OVERFLOW_FLAG_EN
    assign ovf0  = 1'b0;
    assign ovf8  = 1'b0;
    assign ovf32 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        int unsigned cyc;
        int unsigned sc;
    } exp_t;

    exp_t        q [3][$];
    bit          pstall [3];
    logic        pov [3];
    logic        pc [3];
    logic [31:0] ps [3];
    int unsigned sc [3];
    int unsigned popped [3];
    int unsigned cyc = 0;

    task automatic mon(input int id, input int unsigned n, input int unsigned w,
                       input logic inv, input logic irdy, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic ov,
                       input logic ordy, input logic [31:0] s, input logic co,
                       input logic of);
        logic [32:0] full;
        logic [31:0] mask;
        exp_t        e;
        string       p;
        p = $sformatf("w%0d_", w);
        if (rst) begin
            q[id].delete();
            pstall[id] = 1'b0;
            return;
        end
        chk(irdy == !(ov && !ordy), {p, "in_ready"}, 64'(irdy), 64'(!(ov && !ordy)));
        if (!ov)
            chk(s == 0 && co == 1'b0 && of == 1'b0, {p, "idle_zero"}, 64'({of, co, s}), 64'(0));
        if (pstall[id])
            chk(ov == pov[id] && s == ps[id] && co == pc[id], {p, "stall_hold"},
                64'({ov, co, s}), 64'({pov[id], pc[id], ps[id]}));
        if (ov && !pstall[id]) begin
            if (q[id].size() == 0) begin
                chk(1'b0, {p, "spurious_result"}, 64'(s), 64'(0));
            end else begin
                e = q[id][0];
                chk(cyc == e.cyc + n + (sc[id] - e.sc), {p, "latency"},
                    64'(cyc - e.cyc), 64'(n + (sc[id] - e.sc)));
                chk(s == e.s && co == e.c, {p, "sum"}, 64'({co, s}), 64'({e.c, e.s}));
`ifdef CSA_OVERFLOW_FLAG_EN
                chk(of == e.v, {p, "ovf"}, 64'(of), 64'(e.v));
`endif
            end
        end
        if (ov && ordy && q[id].size() > 0) begin
            void'(q[id].pop_front());
            popped[id]++;
        end
        if (inv && irdy) begin
            full = 33'(a) + 33'(b) + 33'(c);
            mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            e.s   = full[31:0] & mask;
            e.c   = full[w];
            e.v   = (a[w-1] == b[w-1]) && (full[w-1] != a[w-1]);
            e.cyc = cyc;
            e.sc  = sc[id];
            q[id].push_back(e);
        end
        pstall[id] = ov && !ordy;
        if (pstall[id]) sc[id]++;
        pov[id] = ov;
        pc[id]  = co;
        ps[id]  = s;
    endtask

    // Single compare process: outputs sampled on the falling edge.
    always @(negedge clk) begin
        mon(0, N, 16, in_valid, in_ready, 32'(A), 32'(B), cin, out_valid, out_ready, 32'(S), cout, ovf0);
        mon(1, 1, 8, iv8, ir8, 32'(a8), 32'(b8), c8, ov8, or8, 32'(s8), co8, ovf8);
        mon(2, 4, 32, iv32, ir32, a32, b32, c32, ov32, or32, s32, co32, ovf32);
        cyc++;
    end

    // ---------------- directed tests on the 16/4 instance ----------------
    logic last_ovf;

    task automatic one_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [15:0] es, input logic ec, input string nm);
        for (int t = 0; t <= int'(N); t++) begin
            @(posedge clk); #1;
            in_valid = (t == 0);
            A = a; B = b; cin = c;
            @(negedge clk);
            if (t == 0) begin
                chk(in_ready == 1'b1, {nm, "_ready"}, 64'(in_ready), 64'(1));
            end else if (t < int'(N)) begin
                chk(out_valid == 1'b0, {nm, "_early"}, 64'(out_valid), 64'(0));
            end else begin
                chk(out_valid == 1'b1, {nm, "_valid"}, 64'(out_valid), 64'(1));
                chk(S == es, {nm, "_S"}, 64'(S), 64'(es));
                chk(cout == ec, {nm, "_cout"}, 64'(cout), 64'(ec));
                last_ovf = ovf0;
            end
        end
    endtask

    bit sweep_done = 1'b0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cin = 1'b0; last_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'(0));
        chk(S == 16'h0000, "reset_S", 64'(S), 64'(0));
        chk(cout == 1'b0, "reset_cout", 64'(cout), 64'(0));
        chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'(1));

        one_op(16'h0002, 16'h0003, 1'b1, 16'h0006, 1'b0, "basic_cin1");
        one_op(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, "basic_cin0");
        one_op(16'h7FFF, 16'h8000, 1'b1, 16'h0000, 1'b1, "ripple_cin1");
        one_op(16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0, "ripple_cin0");
`ifdef CSA_OVERFLOW_FLAG_EN
        chk(last_ovf == 1'b0, "ripple_ovf", 64'(last_ovf), 64'(0));
        one_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ovf_pos");
        chk(last_ovf == 1'b1, "ovf_pos_flag", 64'(last_ovf), 64'(1));
`endif

        // Back-to-back stream: A=i, B=0xFF*i, cin=i[0] -> S = 0x100*i + i[0]
        for (int t = 0; t < 14; t++) begin
            @(posedge clk); #1;
            in_valid = (t < 8);
            A = 16'(t); B = 16'(255 * t); cin = t[0];
            @(negedge clk);
            chk(in_ready == 1'b1, "stream_ready", 64'(in_ready), 64'(1));
            if (t >= 4 && t < 12) begin
                chk(out_valid == 1'b1, "stream_valid", 64'(out_valid), 64'(1));
                chk(S == 16'(256 * (t - 4) + ((t - 4) % 2)), "stream_S", 64'(S),
                    64'(256 * (t - 4) + ((t - 4) % 2)));
            end else begin
                chk(out_valid == 1'b0, "stream_gap", 64'(out_valid), 64'(0));
            end
        end

        // Backpressure: three in flight, out_ready low for cycles 0..8 (5 stalled cycles).
        for (int t = 0; t < 13; t++) begin
            @(posedge clk); #1;
            in_valid  = (t < 3);
            A = 16'(16'h1000 + t); B = 16'(16'h0111 * t); cin = 1'b1;
            out_ready = (t >= 9);
            @(negedge clk);
            if (t >= 4 && t <= 8) begin
                chk(in_ready == 1'b0, "bp_in_ready", 64'(in_ready), 64'(0));
                chk(out_valid == 1'b1 && S == 16'h1001, "bp_hold_S", 64'(S), 64'(16'h1001));
            end
            if (t == 9)  chk(out_valid && S == 16'h1001 && !cout, "bp_rel0", 64'(S), 64'(16'h1001));
            if (t == 10) chk(out_valid && S == 16'h1113 && !cout, "bp_rel1", 64'(S), 64'(16'h1113));
            if (t == 11) chk(out_valid && S == 16'h1225 && !cout, "bp_rel2", 64'(S), 64'(16'h1225));
            if (t == 12) chk(out_valid == 1'b0, "bp_drained", 64'(out_valid), 64'(0));
        end

        // Reset mid-operation: three accepted, then a one-cycle reset.
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            in_valid = (t < 3);
            A = 16'(16'h1234 + t); B = 16'h4321; cin = 1'b1;
            rst = (t == 3);
            @(negedge clk);
            if (t >= 4)
                chk(out_valid == 1'b0 && S == 16'h0000 && cout == 1'b0, "rst_flush",
                    64'({out_valid, cout, S}), 64'(0));
        end

        for (int i = 0; i < 4000 && !sweep_done; i++) @(posedge clk);
        if (!sweep_done) chk(1'b0, "sweep_timeout", 64'(0), 64'(1));
        repeat (8) @(posedge clk);
        @(negedge clk);
        for (int id = 0; id < 3; id++)
            chk(q[id].size() == 0, $sformatf("drain_%0d", id), 64'(q[id].size()), 64'(0));
        chk(popped[1] > 100, "sweep8_activity", 64'(popped[1]), 64'(101));
        chk(popped[2] > 100, "sweep32_activity", 64'(popped[2]), 64'(101));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- random traffic on the 8/8 and 32/8 instances ----------------
    initial begin
        iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; or32 = 1'b1;
        repeat (5) @(posedge clk);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            iv8  = ($urandom_range(0, 3) != 0);
            a8   = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            or8  = ($urandom_range(0, 3) != 0);
            iv32 = ($urandom_range(0, 3) != 0);
            a32  = $urandom; b32 = $urandom; c32 = 1'($urandom);
            or32 = ($urandom_range(0, 3) != 0);
            if (i % 50 == 0) begin
                a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0000; c32 = 1'b1;
                a8  = 8'h7F; b8 = 8'h01; c8 = 1'b0;
            end
        end
        @(posedge clk); #1;
        iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
        sweep_done = 1'b1;
    end

endmodule

// File: doc/pipelined_carry_select_adder.md
Name: pipelined_carry_select_adder

Overview:
- Parametrised, pipelined carry-select adder; generalises the fixed 8-bit carry-select adder to any width and block size.
- Splits operands into BLOCK-bit blocks, one pipeline stage per block. Each stage precomputes sums for carry-in 0 and 1, then selects using the registered carry from the previous stage.
- Valid/ready handshake on both ends; sits between the operand register file and the ALU result bus.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select block; NUM_STAGES = WIDTH/BLOCK; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B, cin valid this cycle.
- in_ready  output  1  adder accepts an operand set this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  S/cout hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- S  output  WIDTH  sum, (A + B + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst=1 at a clk edge): all stage valid bits 0, all data/carry registers 0. Result: out_valid=0, S=0, cout=0. in_ready=1 from the first cycle after reset. Reset mid-operation discards every in-flight result; nothing emerges afterwards.
- Accept: a transfer occurs when in_valid && in_ready at a clk edge.
- Stage k (0..NUM_STAGES-1):
  - Computes block k as sum0 = a_k + b_k + 0 and sum1 = a_k + b_k + 1, each BLOCK+1 bits.
  - Selects with carry c_k: c_0 = cin; c_k = registered carry from stage k-1.
  - Registers the selected BLOCK sum bits, the carry out, and all not-yet-consumed operand blocks (skew registers).
  - Lower result blocks are carried forward alongside the computation.
- Latency: exactly NUM_STAGES cycles from the accepting edge to out_valid=1 with the matching S/cout (4 cycles at defaults).
- Throughput: one result per cycle when out_ready=1 continuously.
- Ordering: results emerge in acceptance order; no reordering and no drops.
- Stall: if out_valid && !out_ready, the whole pipeline holds (every register keeps its value) and in_ready=0. Otherwise in_ready=1, and the pipeline advances by one stage each cycle, including bubbles.
- out_valid/S/cout are stable while stalled; S/cout may change only on an edge where out_ready=1 or out_valid=0.
- in_ready is combinational from out_valid and out_ready; no other combinational in-to-out paths.
- Bubbles: stages holding no valid data still shift; their data contents are don't-care, but S/cout must be 0 whenever out_valid=0.
- Width rule: S takes the low WIDTH bits of the true sum; cout is bit WIDTH. Operands are unsigned for cout.
- Degenerate case WIDTH==BLOCK: single stage, latency 1.
- Elaboration: WIDTH % BLOCK != 0 is rejected with $error in a generate check.

Optional Feature:
- Macro: CSA_OVERFLOW_FLAG_EN.
- Defined:
  - Extra output ovf (output, 1 bit) = signed two's-complement overflow = carry into bit WIDTH-1 XOR cout.
  - ovf is registered alongside S with the same latency, stall and reset rules.
  - ovf is 0 whenever out_valid=0.
- Undefined: no ovf port and no extra logic. All other behaviour is identical.

Test Plan:
- Basic, out_ready=1 (defaults): A=0x0002, B=0x0003, cin=1 -> after 4 cycles out_valid=1, S=0x0006, cout=0. Same operands with cin=0 -> S=0x0005.
- Full carry ripple across all blocks: A=0x7FFF, B=0x8000, cin=1 -> S=0x0000, cout=1. With cin=0 -> S=0xFFFF, cout=0. With CSA_OVERFLOW_FLAG_EN defined, A=0x7FFF, B=0x0001, cin=0 -> S=0x8000, ovf=1.
- Back-to-back stream of 8 operand pairs, A=i, B=0x00FF*i, cin=i[0], out_ready=1 -> 8 consecutive out_valid cycles starting 4 cycles after the first accept; each S matches the reference sum in order.
- Backpressure: with 3 results in flight, hold out_ready=0 for 5 cycles -> in_ready=0 during the stall; S/cout frozen while out_valid=1. On release, results emerge in order with none lost or duplicated.
- Reset mid-operation: accept 3 pairs, then assert rst for 1 cycle -> out_valid=0, S=0, cout=0 next cycle; no stale result emerges in the following 6 cycles.
- Parameter sweep: WIDTH=8/BLOCK=8 (latency 1) and WIDTH=32/BLOCK=8 (latency 4) with random operands -> all results match A+B+cin.
